// File: rtl/autoenc_pkg.sv
// Shared definitions for the autoencoder training blocks: FSM encoding and
// default dataset/epoch sizes used by the sequencer, counter_mem and datapath.
package autoenc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int DEF_ADDR_W    = 16;
  localparam int DEF_EPOCH_W   = 17;
  localparam int DEF_N_SAMPLES = 332;
  localparam int DEF_N_EPOCHS  = 10000;

endpackage

// File: rtl/train_seq_gen_wrap_counter.sv
// Modulo counter: counts 0..MODULO-1 and wraps, with synchronous clear (wins
// over enable) and a flag raised while the count equals TC.
module wrap_counter #(
  parameter int W      = 16,
  parameter int MODULO = 4,
  parameter int TC     = MODULO - 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         tc
);

  localparam logic [W-1:0] LAST = W'(MODULO - 1);
  localparam logic [W-1:0] TC_V = W'(TC);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;
  assign tc  = (cnt_q == TC_V);

endmodule

// File: rtl/train_seq_gen.sv
// Training-sample index sequencer with epoch counting and completion flag.
// Optional TRAIN_SEQ_PAUSE_EN adds a pause input that withholds addr_valid in RUN.
module train_seq_gen
  import autoenc_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int N_SAMPLES = DEF_N_SAMPLES,
  parameter int EPOCH_W   = DEF_EPOCH_W,
  parameter int N_EPOCHS  = DEF_N_EPOCHS
) (
  input  logic               clk,
  input  logic               rst,
`ifdef TRAIN_SEQ_PAUSE_EN
  input  logic               pause,
`endif
  input  logic               start,
  input  logic               abort,
  input  logic               addr_ready,
  output logic [ADDR_W-1:0]  addr,
  output logic               addr_valid,
  output logic [EPOCH_W-1:0] epoch_cnt,
  output logic               epoch_done,
  output logic               train_done,
  output logic               busy
);

  if (N_SAMPLES > (2 ** ADDR_W)) begin : g_bad_addr_w
    $error("train_seq_gen: N_SAMPLES does not fit in ADDR_W");
  end
  if (N_EPOCHS >= (2 ** EPOCH_W)) begin : g_bad_epoch_w
    $error("train_seq_gen: N_EPOCHS does not fit in EPOCH_W");
  end

  logic pause_i;
`ifdef TRAIN_SEQ_PAUSE_EN
  assign pause_i = pause;
`else
  assign pause_i = 1'b0;
`endif

  state_e state_q, state_d;
  logic   addr_valid_q, addr_valid_d;
  logic   epoch_done_q, epoch_done_d;
  logic   train_done_q, train_done_d;
  logic   busy_q, busy_d;

  logic   smp_clr, smp_en, smp_tc;
  logic   ep_clr, ep_en, ep_last;
  logic   xfer;

  logic [ADDR_W-1:0]  smp_cnt;
  logic [EPOCH_W-1:0] ep_cnt;

  wrap_counter #(
    .W      (ADDR_W),
    .MODULO (N_SAMPLES),
    .TC     (N_SAMPLES - 1)
  ) u_smp_cnt (
    .clk (clk),
    .rst (rst),
    .clr (smp_clr),
    .en  (smp_en),
    .cnt (smp_cnt),
    .tc  (smp_tc)
  );

  // Epoch count must be able to rest at N_EPOCHS, so the modulus is one larger;
  // the flag marks the last epoch in progress.
  wrap_counter #(
    .W      (EPOCH_W),
    .MODULO (N_EPOCHS + 1),
    .TC     (N_EPOCHS - 1)
  ) u_ep_cnt (
    .clk (clk),
    .rst (rst),
    .clr (ep_clr),
    .en  (ep_en),
    .cnt (ep_cnt),
    .tc  (ep_last)
  );

  // Pause masks valid at once but only re-arms it through the flop.
  assign addr_valid = addr_valid_q & ~pause_i;
  assign xfer       = addr_valid & addr_ready;

  always_comb begin
    state_d      = state_q;
    addr_valid_d = addr_valid_q;
    epoch_done_d = 1'b0;
    train_done_d = train_done_q;
    smp_clr      = 1'b0;
    smp_en       = 1'b0;
    ep_clr       = 1'b0;
    ep_en        = 1'b0;

    if (abort) begin
      state_d      = ST_IDLE;
      addr_valid_d = 1'b0;
      train_done_d = 1'b0;
      smp_clr      = 1'b1;
      ep_clr       = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          smp_clr      = 1'b1;
          ep_clr       = 1'b1;
          addr_valid_d = 1'b0;
          if (start) begin
            state_d      = ST_RUN;
            addr_valid_d = ~pause_i;
          end
        end
        ST_RUN: begin
          addr_valid_d = ~pause_i;
          if (xfer) begin
            smp_en = 1'b1;
            if (smp_tc) begin
              ep_en        = 1'b1;
              epoch_done_d = 1'b1;
              if (ep_last) begin
                state_d      = ST_DONE;
                addr_valid_d = 1'b0;
                train_done_d = 1'b1;
              end
            end
          end
        end
        ST_DONE: begin
          addr_valid_d = 1'b0;
          train_done_d = 1'b1;
          if (start) begin
            state_d      = ST_RUN;
            addr_valid_d = ~pause_i;
            train_done_d = 1'b0;
            smp_clr      = 1'b1;
            ep_clr       = 1'b1;
          end
        end
        default: begin
          state_d      = ST_IDLE;
          addr_valid_d = 1'b0;
          train_done_d = 1'b0;
          smp_clr      = 1'b1;
          ep_clr       = 1'b1;
        end
      endcase
    end

    busy_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      addr_valid_q <= 1'b0;
      epoch_done_q <= 1'b0;
      train_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_valid_q <= addr_valid_d;
      epoch_done_q <= epoch_done_d;
      train_done_q <= train_done_d;
      busy_q       <= busy_d;
    end
  end

  assign addr       = smp_cnt;
  assign epoch_cnt  = ep_cnt;
  assign epoch_done = epoch_done_q;
  assign train_done = train_done_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_train_seq_gen.sv
// Bench for train_seq_gen with a transfer-count reference model and directed literal checks.
module tb_train_seq_gen;

  localparam int ADDR_W  = 16;
  localparam int EPOCH_W = 17;
  localparam int NS      = 4;
  localparam int NE      = 3;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic               abort;
  logic               addr_ready;
  logic [ADDR_W-1:0]  addr;
  logic               addr_valid;
  logic [EPOCH_W-1:0] epoch_cnt;
  logic               epoch_done;
  logic               train_done;
  logic               busy;
  logic               pause_now;

`ifdef TRAIN_SEQ_PAUSE_EN
  logic pause;
  assign pause_now = pause;
`else
  assign pause_now = 1'b0;
`endif

  always #5 clk = ~clk;

  train_seq_gen #(
    .ADDR_W    (ADDR_W),
    .N_SAMPLES (NS),
    .EPOCH_W   (EPOCH_W),
    .N_EPOCHS  (NE)
  ) dut (
    .clk        (clk),
    .rst        (rst),
`ifdef TRAIN_SEQ_PAUSE_EN
    .pause      (pause),
`endif
    .start      (start),
    .abort      (abort),
    .addr_ready (addr_ready),
    .addr       (addr),
    .addr_valid (addr_valid),
    .epoch_cnt  (epoch_cnt),
    .epoch_done (epoch_done),
    .train_done (train_done),
    .busy       (busy)
  );

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: mode 0=idle 1=run 2=done; m_n = transfers accepted since start.
  int m_mode;
  int m_n;
  bit m_valid;
  bit m_edone;
  bit m_xfer;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode = 0; m_n = 0; m_valid = 1'b0; m_edone = 1'b0;
    end else begin
      m_xfer  = m_valid && !pause_now && addr_ready;
      m_edone = 1'b0;
      if (abort) begin
        m_mode = 0; m_n = 0; m_valid = 1'b0;
      end else if (m_mode == 1) begin
        m_valid = !pause_now;
        if (m_xfer) begin
          m_n++;
          if (m_n % NS == 0) m_edone = 1'b1;
          if (m_n == NS * NE) begin
            m_mode  = 2;
            m_valid = 1'b0;
          end
        end
      end else if (start) begin
        m_mode = 1; m_n = 0; m_valid = !pause_now;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("addr",       32'(addr),       32'(m_n % NS));
      check("epoch_cnt",  32'(epoch_cnt),  32'(m_n / NS));
      check("addr_valid", 32'(addr_valid), 32'(m_valid && !pause_now));
      check("epoch_done", 32'(epoch_done), 32'(m_edone));
      check("train_done", 32'(train_done), 32'(m_mode == 2));
      check("busy",       32'(busy),       32'(m_mode == 1));
    end
  end

  task automatic nedge();
    @(negedge clk);
    #1;
  endtask

  bit pat [8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; addr_ready = 1'b0;
`ifdef TRAIN_SEQ_PAUSE_EN
    pause = 1'b0;
`endif
    repeat (3) nedge();
    check("rst_addr_valid", 32'(addr_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    chk_en = 1'b1;

    // Idle with start low.
    repeat (10) nedge();
    check("idle_addr_valid", 32'(addr_valid), 32'd0);

    // Asynchronous reset mid-run.
    start = 1'b1; addr_ready = 1'b1;
    nedge();
    start = 1'b0;
    repeat (5) nedge();
    check("pre_rst_epoch", 32'(epoch_cnt), 32'd1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_addr", 32'(addr), 32'd0);
    check("arst_valid", 32'(addr_valid), 32'd0);
    check("arst_epoch", 32'(epoch_cnt), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_tdone", 32'(train_done), 32'd0);
    nedge();
    rst = 1'b0;
    nedge();

    // Basic run with ready held high.
    start = 1'b1; addr_ready = 1'b1;
    nedge();
    start = 1'b0;
    for (int k = 0; k < NS * NE; k++) begin
      check("seq_addr", 32'(addr), 32'(k % NS));
      check("seq_edone", 32'(epoch_done), 32'((k > 0) && (k % NS == 0)));
      check("seq_valid", 32'(addr_valid), 32'd1);
      nedge();
    end
    check("end_tdone", 32'(train_done), 32'd1);
    check("end_epoch", 32'(epoch_cnt), 32'(NE));
    check("end_valid", 32'(addr_valid), 32'd0);
    check("end_edone", 32'(epoch_done), 32'd1);
    nedge();
    check("done_hold_addr", 32'(addr), 32'd0);

    // Restart from DONE, then backpressure pattern.
    start = 1'b1; addr_ready = 1'b0;
    nedge();
    start = 1'b0;
    check("restart_epoch", 32'(epoch_cnt), 32'd0);
    check("restart_valid", 32'(addr_valid), 32'd1);
    check("restart_tdone", 32'(train_done), 32'd0);
    for (int i = 0; i < 8; i++) begin
      addr_ready = pat[i];
      nedge();
    end
    check("bp_addr", 32'(addr), 32'd0);
    check("bp_epoch", 32'(epoch_cnt), 32'd1);
    check("bp_edone", 32'(epoch_done), 32'd1);

    // Abort at addr 2 of epoch 1, then start+abort together.
    addr_ready = 1'b1;
    nedge();
    nedge();
    check("pre_abort_addr", 32'(addr), 32'd2);
    abort = 1'b1;
    nedge();
    abort = 1'b0;
    check("abort_addr", 32'(addr), 32'd0);
    check("abort_epoch", 32'(epoch_cnt), 32'd0);
    check("abort_valid", 32'(addr_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    start = 1'b1; abort = 1'b1;
    nedge();
    start = 1'b0; abort = 1'b0;
    check("start_abort_valid", 32'(addr_valid), 32'd0);
    check("start_abort_busy", 32'(busy), 32'd0);

`ifdef TRAIN_SEQ_PAUSE_EN
    start = 1'b1; addr_ready = 1'b1;
    nedge();
    start = 1'b0;
    nedge();
    nedge();
    check("pre_pause_addr", 32'(addr), 32'd2);
    pause = 1'b1;
    repeat (5) nedge();
    check("pause_addr", 32'(addr), 32'd2);
    check("pause_valid", 32'(addr_valid), 32'd0);
    pause = 1'b0;
    nedge();
    check("unpause_addr", 32'(addr), 32'd2);
    check("unpause_valid", 32'(addr_valid), 32'd1);
    nedge();
    check("unpause_next", 32'(addr), 32'd3);
    abort = 1'b1;
    nedge();
    abort = 1'b0;
`endif

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      start      = ($urandom_range(0, 7) == 0);
      abort      = ($urandom_range(0, 63) == 0);
      addr_ready = ($urandom_range(0, 1) == 1);
`ifdef TRAIN_SEQ_PAUSE_EN
      pause      = ($urandom_range(0, 5) == 0);
`endif
      nedge();
    end

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
